// File: rtl/iec_sd_arbiter_pkg.sv
// Shared types and helpers for the SD-channel arbiter and the drive selector.
package iec_sd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      XFER = 2'd2
   } state_e;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_e;

   function automatic int NDR_CLAMP(input int drives);
      if (drives < 1) return 1;
      if (drives > 4) return 4;
      return drives;
   endfunction

endpackage

// File: rtl/iec_sd_arbiter_if.sv
// Per-drive SD ports plus the single host SD channel, bundled for the arbiter.
interface iec_sd_arbiter_if #(
   parameter int NDR = 2
);
   logic [31:0]    dev_lba      [NDR];
   logic [5:0]     dev_sz       [NDR];
   logic [NDR-1:0] dev_rd;
   logic [NDR-1:0] dev_wr;
   logic [NDR-1:0] dev_ack;
   logic [7:0]     dev_buff_din [NDR];
   logic [NDR-1:0] dev_buff_wr;

   logic [31:0]    sd_lba;
   logic [5:0]     sd_sz;
   logic           sd_rd;
   logic           sd_wr;
   logic           sd_ack;
   logic [7:0]     sd_buff_din;
   logic           sd_buff_wr;

   // master: the arbiter; slave: drives plus host around it
   modport master (
      input  dev_lba, dev_sz, dev_rd, dev_wr, dev_buff_din, sd_ack, sd_buff_wr,
      output dev_ack, dev_buff_wr, sd_lba, sd_sz, sd_rd, sd_wr, sd_buff_din
   );

   modport slave (
      output dev_lba, dev_sz, dev_rd, dev_wr, dev_buff_din, sd_ack, sd_buff_wr,
      input  dev_ack, dev_buff_wr, sd_lba, sd_sz, sd_rd, sd_wr, sd_buff_din
   );
endinterface

// File: rtl/iec_sd_arbiter_rr_pick.sv
// Combinational round-robin picker: first pending index after ptr, wrapping.
module rr_pick #(
   parameter int NDR = 2
) (
   input  logic [NDR-1:0] pending,
   input  logic [1:0]     ptr,
   output logic           valid,
   output logic [1:0]     idx
);
   // Scan from the farthest candidate down so the nearest one after ptr wins.
   always_comb begin
      valid = 1'b0;
      idx   = 2'd0;
      for (int k = NDR; k >= 1; k--) begin
         if (pending[(int'(ptr) + k) % NDR]) begin
            valid = 1'b1;
            idx   = 2'((int'(ptr) + k) % NDR);
         end
      end
   end
endmodule

// File: rtl/iec_sd_arbiter.sv
// Round-robin sharing of one host SD channel between up to four drives.
//   state | meaning
//   IDLE  | no grant; requesters sampled, winner latched
//   REQ   | host sd_rd/sd_wr asserted, waiting for sd_ack (or timeout)
//   XFER  | host acked; data routed to/from granted drive until ack falls
module iec_sd_arbiter
   import iec_sd_pkg::*;
#(
   parameter int DRIVES  = 2,
   parameter int TIMEOUT = 4_000_000
) (
   input  logic              clk_sys,
   input  logic              reset,
   iec_sd_arbiter_if.master  bus,
   output logic              busy,
   output logic [1:0]        grant
);
   localparam int          NDR     = NDR_CLAMP(DRIVES);
   localparam logic [1:0]  PTR_RST = 2'(NDR - 1);
   localparam logic [31:0] TO_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

   state_e      state_q, state_d;
   logic [1:0]  grant_q, grant_d;
   logic [1:0]  ptr_q,   ptr_d;
   logic [31:0] lba_q,   lba_d;
   logic [5:0]  sz_q,    sz_d;
   logic        rd_q,    rd_d;
   logic        wr_q,    wr_d;
   logic [31:0] cnt_q,   cnt_d;

   logic [NDR-1:0] pending;
   logic           pick_valid;
   logic [1:0]     pick_idx;
   op_e            pick_op;
   logic [31:0]    pick_lba;
   logic [5:0]     pick_sz;
   logic [7:0]     din_sel;
   logic           timed_out;

   assign pending = bus.dev_rd | bus.dev_wr;

   rr_pick #(.NDR(NDR)) u_pick (
      .pending (pending),
      .ptr     (ptr_q),
      .valid   (pick_valid),
      .idx     (pick_idx)
   );

   always_comb begin
      pick_lba = '0;
      pick_sz  = '0;
      pick_op  = OP_RD;
      din_sel  = '0;
      for (int i = 0; i < NDR; i++) begin
         if (pick_idx == 2'(i)) begin
            pick_lba = bus.dev_lba[i];
            pick_sz  = bus.dev_sz[i];
            pick_op  = bus.dev_wr[i] ? OP_WR : OP_RD;
         end
         if (grant_q == 2'(i)) din_sel = bus.dev_buff_din[i];
      end
   end

   assign timed_out = (TIMEOUT != 0) && (cnt_q == TO_LAST);

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      lba_d   = lba_q;
      sz_d    = sz_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               grant_d = pick_idx;
               lba_d   = pick_lba;
               sz_d    = pick_sz;
               rd_d    = (pick_op == OP_RD);
               wr_d    = (pick_op == OP_WR);
               cnt_d   = '0;
               state_d = REQ;
            end
         end
         REQ: begin
            if (bus.sd_ack) begin
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               state_d = XFER;
            end else if (timed_out) begin
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               ptr_d   = grant_q;
               state_d = IDLE;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         XFER: begin
            if (!bus.sd_ack) begin
               ptr_d   = grant_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q <= IDLE;
         grant_q <= 2'd0;
         ptr_q   <= PTR_RST;
         lba_q   <= '0;
         sz_q    <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         lba_q   <= lba_d;
         sz_q    <= sz_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         cnt_q   <= cnt_d;
      end
   end

   // Host strobes reach only the granted drive, and never while idle.
   always_comb begin
      bus.dev_ack     = '0;
      bus.dev_buff_wr = '0;
      for (int i = 0; i < NDR; i++) begin
         bus.dev_ack[i]     = bus.sd_ack     && (grant_q == 2'(i)) && (state_q != IDLE);
         bus.dev_buff_wr[i] = bus.sd_buff_wr && (grant_q == 2'(i)) && (state_q != IDLE);
      end
   end

   assign bus.sd_lba      = lba_q;
   assign bus.sd_sz       = sz_q;
   assign bus.sd_rd       = rd_q;
   assign bus.sd_wr       = wr_q;
   assign bus.sd_buff_din = din_sel;
   assign busy            = (state_q != IDLE);
   assign grant           = grant_q;
endmodule

// File: tb/tb_iec_sd_arbiter.sv
// Directed bench for iec_sd_arbiter: two drives, 16-cycle request timeout.
module tb_iec_sd_arbiter;
   logic       clk_sys = 1'b0;
   logic       reset   = 1'b1;
   logic       busy;
   logic [1:0] grant;
   int         n_tests = 0;
   int         n_fail  = 0;

   iec_sd_arbiter_if #(.NDR(2)) bus ();

   iec_sd_arbiter #(.DRIVES(2), .TIMEOUT(16)) dut (
      .clk_sys (clk_sys),
      .reset   (reset),
      .bus     (bus),
      .busy    (busy),
      .grant   (grant)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tests++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk_sys);
   endtask

   // One full handshake for an already-requesting drive g (read op).
   task automatic round(input logic [1:0] g);
      chk("rr_grant", 32'(grant), 32'(g));
      chk("rr_sd_rd", 32'(bus.sd_rd), 32'd1);
      chk("rr_busy", 32'(busy), 32'd1);
      bus.sd_ack = 1'b1;
      #1 chk("rr_dev_ack", 32'(bus.dev_ack), 32'(2'b01 << g));
      tick();
      chk("rr_rd_low", 32'(bus.sd_rd), 32'd0);
      bus.sd_ack = 1'b0;
      tick();
      chk("rr_idle_gap", 32'(busy), 32'd0);
      tick();
   endtask

   initial begin
      int cnt0, cnt1, n;
      bus.dev_lba[0] = 32'h0; bus.dev_lba[1] = 32'h0;
      bus.dev_sz[0]  = 6'd0;  bus.dev_sz[1]  = 6'd0;
      bus.dev_buff_din[0] = 8'h00; bus.dev_buff_din[1] = 8'h00;
      bus.dev_rd = 2'b00; bus.dev_wr = 2'b00;
      bus.sd_ack = 1'b0; bus.sd_buff_wr = 1'b0;

      // reset state
      tick(2);
      reset = 1'b0;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_sd_rd", 32'(bus.sd_rd), 32'd0);
      chk("rst_sd_wr", 32'(bus.sd_wr), 32'd0);
      chk("rst_sd_lba", bus.sd_lba, 32'd0);
      chk("rst_grant", 32'(grant), 32'd0);

      // single request on drive 1
      bus.dev_rd = 2'b10; bus.dev_lba[1] = 32'h0000_0123; bus.dev_sz[1] = 6'd1;
      tick();
      chk("s_sd_rd", 32'(bus.sd_rd), 32'd1);
      chk("s_sd_lba", bus.sd_lba, 32'h123);
      chk("s_sd_sz", 32'(bus.sd_sz), 32'd1);
      chk("s_grant", 32'(grant), 32'd1);
      bus.dev_rd = 2'b00;
      tick(4);
      chk("s_rd_held", 32'(bus.sd_rd), 32'd1);
      bus.sd_ack = 1'b1;
      #1 chk("s_dev_ack", 32'(bus.dev_ack), 32'b10);
      tick();
      chk("s_rd_low", 32'(bus.sd_rd), 32'd0);
      chk("s_dev_ack_x", 32'(bus.dev_ack), 32'b10);
      bus.sd_ack = 1'b0;
      tick();
      chk("s_idle", 32'(busy), 32'd0);
      chk("s_grant_kept", 32'(grant), 32'd1);

      // contention right after reset: 0, 1, then 0 again
      reset = 1'b1; tick(); reset = 1'b0;
      bus.dev_rd = 2'b11; bus.dev_lba[0] = 32'hAAAA_0000; bus.dev_sz[0] = 6'd3;
      tick();
      chk("c_lba0", bus.sd_lba, 32'hAAAA_0000);
      round(2'd0);
      round(2'd1);
      bus.dev_rd = 2'b00;
      round(2'd0);
      chk("c_stay_idle", 32'(busy), 32'd0);

      // rd+wr on drive 0: write wins; din routed from drive 0
      bus.dev_rd = 2'b01; bus.dev_wr = 2'b01;
      bus.dev_buff_din[0] = 8'hA5; bus.dev_buff_din[1] = 8'h5A;
      tick();
      chk("w_sd_wr", 32'(bus.sd_wr), 32'd1);
      chk("w_sd_rd", 32'(bus.sd_rd), 32'd0);
      chk("w_grant", 32'(grant), 32'd0);
      bus.dev_rd = 2'b00; bus.dev_wr = 2'b00;
      bus.sd_ack = 1'b1;
      #1 chk("w_din_a5", 32'(bus.sd_buff_din), 32'hA5);
      tick();
      chk("w_wr_low", 32'(bus.sd_wr), 32'd0);
      bus.dev_buff_din[0] = 8'h3C;
      #1 chk("w_din_3c", 32'(bus.sd_buff_din), 32'h3C);
      bus.sd_ack = 1'b0;
      tick(2);

      // 512 buffer strobes with grant = 1
      bus.dev_rd = 2'b10;
      tick();
      chk("b_grant", 32'(grant), 32'd1);
      bus.dev_rd = 2'b00;
      bus.sd_ack = 1'b1;
      tick();
      cnt0 = 0; cnt1 = 0;
      for (int p = 0; p < 512; p++) begin
         bus.sd_buff_wr = 1'b1;
         #1;
         if (bus.dev_buff_wr[0]) cnt0++;
         if (bus.dev_buff_wr[1]) cnt1++;
         tick();
         bus.sd_buff_wr = 1'b0;
         tick();
      end
      chk("b_pulses1", 32'(cnt1), 32'd512);
      chk("b_pulses0", 32'(cnt0), 32'd0);
      bus.sd_ack = 1'b0;
      tick();
      bus.sd_buff_wr = 1'b1;
      #1 chk("b_idle_gate", 32'(bus.dev_buff_wr), 32'd0);
      bus.sd_buff_wr = 1'b0;
      tick();

      // timeout: drive 0 requests, host never acks
      bus.dev_rd = 2'b01;
      tick();
      chk("t_rd_rise", 32'(bus.sd_rd), 32'd1);
      n = 0;
      while (bus.sd_rd && n < 40) begin
         tick();
         n++;
      end
      chk("t_cycles", 32'(n), 32'd16);
      chk("t_idle", 32'(busy), 32'd0);
      tick();
      chk("t_regrant_rd", 32'(bus.sd_rd), 32'd1);
      chk("t_regrant_g", 32'(grant), 32'd0);

      // reset mid-transfer with ack held high
      bus.sd_ack = 1'b1;
      tick();
      chk("r_xfer_ack", 32'(bus.dev_ack), 32'b01);
      bus.dev_rd = 2'b11;
      reset = 1'b1;
      tick();
      chk("r_dev_ack", 32'(bus.dev_ack), 32'd0);
      chk("r_sd_rd", 32'(bus.sd_rd), 32'd0);
      chk("r_sd_wr", 32'(bus.sd_wr), 32'd0);
      chk("r_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      bus.sd_ack = 1'b0;
      tick();
      chk("r_next_grant", 32'(grant), 32'd0);
      chk("r_next_rd", 32'(bus.sd_rd), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
